f1_reaction_timer: RTL and testbench
====================================

Name: f1_reaction_timer

Overview:
Receiving end of the F1 start-light sequence. Watches the 8-bit light pattern driven by the light sequencer and detects a complete run: all lights on, then lights out. It then measures, in tick units, the delay until the driver presses the button. It flags jump starts, abandoned sequences and timeouts, and holds the result until the host clears it.

Parameters:
- CNT_W, 12, width of the reaction counter and result.
- TIMEOUT, 12'd2000, tick count at which timing gives up (must be ≤ 2^CNT_W-1).

Ports:
- clk  input  1  system clock, all state updated on rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronous to clk.
- lights  input  8  light pattern from the sequencer, sampled every clk.
- tick  input  1  single-cycle timebase strobe (e.g. 1 ms).
- btn  input  1  driver button, already synchronised, level-sensitive; edge-detected internally.
- clr  input  1  single-cycle result acknowledge.
- reaction_time  output  CNT_W  captured reaction count.
- valid  output  1  high while a reaction_time result is held.
- jump_start  output  1  high while a jump-start result is held.
- timeout  output  1  high while a timeout result is held.
- busy  output  1  high in ARMED or TIMING.

Behaviour:
- Reset values:
  - state = IDLE.
  - cnt, reaction_time = 0.
  - valid, jump_start, timeout, busy = 0.
  - btn_q = 0.
- Press event: press = btn & ~btn_q, where btn_q is btn registered every cycle. A button held through a state change produces no press.
- States are IDLE, ARMED, TIMING, DONE, FAULT.
- IDLE:
  - lights == 8'hFF -> ARMED.
  - Presses are ignored.
- ARMED (busy=1):
  - Priority order: press first, then lights == 8'h00, then any other value, then 8'hFF.
  - press -> FAULT, with jump_start=1.
  - lights == 8'h00 -> TIMING, with cnt=0.
  - lights any other value than 8'h00/8'hFF -> IDLE (abandoned sequence, no flag).
  - 8'hFF -> stay in ARMED.
- TIMING (busy=1):
  - On tick, cnt increments by 1.
  - Define the effective count as cnt+tick.
  - press -> DONE. reaction_time = effective count; valid=1.
  - If there is no press and the effective count reaches TIMEOUT -> DONE. reaction_time = TIMEOUT; valid=1, timeout=1.
  - A press in the same cycle as the timeout takes priority: timeout=0.
  - The lights value is ignored in TIMING.
- DONE / FAULT:
  - Outputs hold.
  - clr -> IDLE. In the next cycle valid, jump_start and timeout are 0; reaction_time keeps its last value.
  - lights == 8'hFF while in DONE/FAULT without clr: stay. A new round requires clr first.
- Latency:
  - Flags and reaction_time are registered and visible the cycle after the triggering edge.
  - busy is decoded from the state register.
- Arithmetic: cnt never exceeds TIMEOUT, so it cannot wrap.
- Reset mid-operation: everything returns to reset values asynchronously. Any in-flight measurement is lost.

Optional Feature:
- Macro: F1_BEST_TIME_EN.
- When defined:
  - Adds output best_time [CNT_W-1:0], reset to all ones.
  - best_time is updated on entry to DONE with valid && !timeout, when reaction_time < best_time.
  - It is not cleared by clr; only rst clears it.
  - Jump starts and timeouts never update it.
- When undefined: no port, no register; behaviour is otherwise identical.

Test Plan:
- Normal run: lights 0→1→…→FF, then 00; 37 ticks; btn rises -> reaction_time=37, valid=1, timeout=0; clr -> valid=0 next cycle.
- Jump start: lights=FF, btn rises before lights=00 -> jump_start=1, valid=0, reaction_time unchanged; lights=00 afterwards stays in FAULT until clr.
- Held button: btn held high from ARMED into TIMING, then 20 ticks -> no capture; release, then press after 25 ticks total -> reaction_time=25.
- Timeout: TIMEOUT=2000, no press -> after 2000th tick valid=1, timeout=1, reaction_time=2000; press with the 2000th tick in the same cycle -> timeout=0, reaction_time=2000.
- Abandon/reset:
  - ARMED, then lights=8'h7F -> IDLE, all flags 0.
  - In TIMING at cnt=10, assert rst=0 mid-cycle -> outputs 0 immediately; state is IDLE after release.
- Best time (F1_BEST_TIME_EN): runs of 50, 30, 40 ticks plus one timeout -> best_time=30; after clr still 30; after rst all ones.

Source files
------------

// File: rtl/f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : f1_reaction_timer
// Purpose  : Receiving end of the F1 start-light sequence. Detects a full
//            lights-on / lights-out run, counts ticks until the driver's
//            button press and reports reaction time, jump start or timeout.
//            The result is held until the host acknowledges it with clr.
// Options  : F1_BEST_TIME_EN - adds a best_time output that keeps the
//            fastest valid (non-timeout) reaction since the last reset.
// Revision : 1.0 - initial release
// ============================================================================
module f1_reaction_timer #(
    parameter int unsigned      CNT_W   = 12,
    parameter logic [CNT_W-1:0] TIMEOUT = 12'd2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       lights,
    input  logic             tick,
    input  logic             btn,
    input  logic             clr,
    output logic [CNT_W-1:0] reaction_time,
    output logic             valid,
    output logic             jump_start,
    output logic             timeout,
`ifdef F1_BEST_TIME_EN
    output logic [CNT_W-1:0] best_time,
`endif
    output logic             busy
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ARMED  = 3'd1;
    localparam logic [2:0] c_ST_TIMING = 3'd2;
    localparam logic [2:0] c_ST_DONE   = 3'd3;
    localparam logic [2:0] c_ST_FAULT  = 3'd4;

    localparam logic [7:0] c_ALL_ON  = 8'hFF;
    localparam logic [7:0] c_ALL_OFF = 8'h00;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] res_q, res_d;
    logic             valid_q, valid_d;
    logic             jump_q, jump_d;
    logic             to_q, to_d;
    logic             btn_q;

    logic             press;
    logic [CNT_W-1:0] eff_cnt;

    // A press is a rising edge only, so a button held across a state
    // change never counts. The effective count folds in this cycle's tick.
    assign press   = btn & ~btn_q;
    assign eff_cnt = cnt_q + {{(CNT_W-1){1'b0}}, tick};

    // State register plus all registered result/flag state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            jump_q  <= 1'b0;
            to_q    <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            jump_q  <= jump_d;
            to_q    <= to_d;
            btn_q   <= btn;
        end
    end

    // Next-state and next-result decode; press always outranks the lights.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        valid_d = valid_q;
        jump_d  = jump_q;
        to_d    = to_q;
        case (state_q)
            c_ST_IDLE: begin
                if (lights == c_ALL_ON) begin
                    state_d = c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                if (press) begin
                    state_d = c_ST_FAULT;
                    jump_d  = 1'b1;
                end else if (lights == c_ALL_OFF) begin
                    state_d = c_ST_TIMING;
                    cnt_d   = '0;
                end else if (lights != c_ALL_ON) begin
                    // Sequence abandoned part way: quietly start over.
                    state_d = c_ST_IDLE;
                end
            end
            c_ST_TIMING: begin
                if (press) begin
                    state_d = c_ST_DONE;
                    res_d   = eff_cnt;
                    valid_d = 1'b1;
                    to_d    = 1'b0;
                end else if (eff_cnt >= TIMEOUT) begin
                    state_d = c_ST_DONE;
                    res_d   = TIMEOUT;
                    valid_d = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = eff_cnt;
                end
            end
            c_ST_DONE, c_ST_FAULT: begin
                // Result is frozen until acknowledged; reaction_time is
                // deliberately left holding its last value.
                if (clr) begin
                    state_d = c_ST_IDLE;
                    valid_d = 1'b0;
                    jump_d  = 1'b0;
                    to_d    = 1'b0;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                valid_d = 1'b0;
                jump_d  = 1'b0;
                to_d    = 1'b0;
            end
        endcase
    end

    // Output decode: busy comes straight from the state register.
    always_comb begin
        busy          = (state_q == c_ST_ARMED) || (state_q == c_ST_TIMING);
        reaction_time = res_q;
        valid         = valid_q;
        jump_start    = jump_q;
        timeout       = to_q;
    end

`ifdef F1_BEST_TIME_EN
    logic [CNT_W-1:0] best_q;

    // Track the fastest genuine reaction; only reset clears it, not clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_q <= '1;
        end else if ((state_q == c_ST_TIMING) && (state_d == c_ST_DONE) &&
                     valid_d && !to_d && (res_d < best_q)) begin
            best_q <= res_d;
        end
    end

    assign best_time = best_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_f1_reaction_timer
// Purpose  : Self-checking bench for f1_reaction_timer. Rounds are built from
//            randomised tick counts, tick spacing and light noise; expected
//            results are computed from the round description itself.
// Options  : F1_BEST_TIME_EN - also exercises the best_time output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f1_reaction_timer;

    localparam int TMO = 2000;

    logic        clk;
    logic        rst;
    logic [7:0]  lights;
    logic        tick;
    logic        btn;
    logic        clr;
    logic [11:0] reaction_time;
    logic        valid;
    logic        jump_start;
    logic        timeout;
    logic        busy;
`ifdef F1_BEST_TIME_EN
    logic [11:0] best_time;
`endif

    int pass_cnt      = 0;
    int total_cnt     = 0;
    int last_reaction = 0;
    int best_model    = 4095;

    f1_reaction_timer #(
        .CNT_W   (12),
        .TIMEOUT (12'd2000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lights        (lights),
        .tick          (tick),
        .btn           (btn),
        .clr           (clr),
        .reaction_time (reaction_time),
        .valid         (valid),
        .jump_start    (jump_start),
        .timeout       (timeout),
`ifdef F1_BEST_TIME_EN
        .best_time     (best_time),
`endif
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1);
    end

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Walk the lights up to all-on, which arms the receiver from idle.
    task automatic arm();
        for (int i = 1; i <= 8; i++) begin
            lights = 8'((1 << i) - 1);
            cyc();
        end
    endtask

    // Lights out: starts the reaction window.
    task automatic go();
        lights = 8'h00;
        cyc();
    endtask

    // Deliver n ticks with random spacing and random light noise.
    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                tick = 1'b0; lights = 8'($urandom); cyc();
            end
            tick = 1'b1; lights = 8'($urandom); cyc();
        end
        tick = 1'b0;
    endtask

    // One complete measured round: n ticks then a press (optionally
    // coinciding with one more tick), then acknowledge.
    task automatic run_round(input int n, input bit tick_on_press, input string tag);
        int exp_rt;
        exp_rt = n + int'(tick_on_press);
        arm();
        go();
        send_ticks(n);
        total_cnt++;
        if (valid !== 1'b0 || busy !== 1'b1) $display("FAIL %s_pre valid=%0b busy=%0b expected valid=0 busy=1", tag, valid, busy);
        else pass_cnt++;
        btn = 1'b1; tick = tick_on_press; cyc();
        btn = 1'b0; tick = 1'b0;
        total_cnt++;
        if (valid !== 1'b1 || timeout !== 1'b0 || jump_start !== 1'b0 || busy !== 1'b0 || reaction_time !== 12'(exp_rt))
            $display("FAIL %s_capture rt=%0d v=%0b to=%0b js=%0b busy=%0b expected rt=%0d v=1 to=0 js=0 busy=0",
                     tag, reaction_time, valid, timeout, jump_start, busy, exp_rt);
        else pass_cnt++;
        last_reaction = exp_rt;
        if (exp_rt < best_model) best_model = exp_rt;
`ifdef F1_BEST_TIME_EN
        total_cnt++;
        if (best_time !== 12'(best_model)) $display("FAIL %s_best best=%0d expected %0d", tag, best_time, best_model);
        else pass_cnt++;
`endif
        lights = 8'hFF; cyc();
        total_cnt++;
        if (valid !== 1'b1 || reaction_time !== 12'(exp_rt)) $display("FAIL %s_hold rt=%0d v=%0b expected rt=%0d v=1", tag, reaction_time, valid, exp_rt);
        else pass_cnt++;
        clr = 1'b1; lights = 8'h00; cyc(); clr = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || jump_start !== 1'b0 || timeout !== 1'b0 || reaction_time !== 12'(exp_rt))
            $display("FAIL %s_clr rt=%0d v=%0b js=%0b to=%0b expected rt=%0d flags=0", tag, reaction_time, valid, jump_start, timeout, exp_rt);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0; lights = 8'h00; tick = 1'b0; btn = 1'b0; clr = 1'b0;
        cyc(); cyc();
        total_cnt++;
        if (reaction_time !== 12'd0 || valid !== 1'b0 || jump_start !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset rt=%0d v=%0b js=%0b to=%0b busy=%0b expected all 0", reaction_time, valid, jump_start, timeout, busy);
        else pass_cnt++;
`ifdef F1_BEST_TIME_EN
        total_cnt++;
        if (best_time !== 12'hFFF) $display("FAIL reset_best best=%0d expected 4095", best_time);
        else pass_cnt++;
`endif
        #3 rst = 1'b1;
        cyc();
    endtask

    task automatic test_normal();
        run_round(37, 1'b0, "normal");
    endtask

    task automatic test_jump_start();
        arm();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL jump_armed busy=%0b expected 1", busy);
        else pass_cnt++;
        btn = 1'b1; cyc();
        total_cnt++;
        if (jump_start !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || reaction_time !== 12'(last_reaction))
            $display("FAIL jump_flag js=%0b v=%0b busy=%0b rt=%0d expected js=1 v=0 busy=0 rt=%0d", jump_start, valid, busy, reaction_time, last_reaction);
        else pass_cnt++;
        btn = 1'b0; lights = 8'h00;
        for (int i = 0; i < 4; i++) cyc();
        lights = 8'hFF; tick = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        tick = 1'b0;
        total_cnt++;
        if (jump_start !== 1'b1 || busy !== 1'b0) $display("FAIL jump_hold js=%0b busy=%0b expected js=1 busy=0", jump_start, busy);
        else pass_cnt++;
        clr = 1'b1; lights = 8'h00; cyc(); clr = 1'b0;
        total_cnt++;
        if (jump_start !== 1'b0 || busy !== 1'b0) $display("FAIL jump_clr js=%0b busy=%0b expected 0 0", jump_start, busy);
        else pass_cnt++;
    endtask

    task automatic test_held_button();
        btn = 1'b1; lights = 8'h00; cyc();
        arm();
        total_cnt++;
        if (busy !== 1'b1 || jump_start !== 1'b0) $display("FAIL held_arm busy=%0b js=%0b expected busy=1 js=0", busy, jump_start);
        else pass_cnt++;
        go();
        send_ticks(20);
        total_cnt++;
        if (valid !== 1'b0 || busy !== 1'b1) $display("FAIL held_nocap v=%0b busy=%0b expected v=0 busy=1", valid, busy);
        else pass_cnt++;
        btn = 1'b0; cyc();
        send_ticks(5);
        btn = 1'b1; cyc(); btn = 1'b0;
        total_cnt++;
        if (valid !== 1'b1 || reaction_time !== 12'd25) $display("FAIL held_capture rt=%0d v=%0b expected rt=25 v=1", reaction_time, valid);
        else pass_cnt++;
        last_reaction = 25;
        if (25 < best_model) best_model = 25;
        clr = 1'b1; cyc(); clr = 1'b0;
    endtask

    task automatic test_timeout(input bit press_on_last);
        arm();
        go();
        tick = 1'b1;
        for (int i = 0; i < TMO - 1; i++) cyc();
        total_cnt++;
        if (valid !== 1'b0 || busy !== 1'b1) $display("FAIL tmo_pre%0b v=%0b busy=%0b expected v=0 busy=1", press_on_last, valid, busy);
        else pass_cnt++;
        btn = press_on_last; cyc();
        tick = 1'b0; btn = 1'b0;
        total_cnt++;
        if (valid !== 1'b1 || timeout !== !press_on_last || reaction_time !== 12'(TMO) || busy !== 1'b0)
            $display("FAIL tmo_capture%0b rt=%0d v=%0b to=%0b busy=%0b expected rt=%0d v=1 to=%0b busy=0",
                     press_on_last, reaction_time, valid, timeout, busy, TMO, !press_on_last);
        else pass_cnt++;
        last_reaction = TMO;
        if (press_on_last && TMO < best_model) best_model = TMO;
        clr = 1'b1; cyc(); clr = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || timeout !== 1'b0) $display("FAIL tmo_clr%0b v=%0b to=%0b expected 0 0", press_on_last, valid, timeout);
        else pass_cnt++;
    endtask

    task automatic test_abandon_and_reset();
        arm();
        lights = 8'h7F; cyc();
        total_cnt++;
        if (busy !== 1'b0 || valid !== 1'b0 || jump_start !== 1'b0 || timeout !== 1'b0)
            $display("FAIL abandon busy=%0b v=%0b js=%0b to=%0b expected all 0", busy, valid, jump_start, timeout);
        else pass_cnt++;
        lights = 8'h00; cyc();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL abandon_idle busy=%0b expected 0", busy);
        else pass_cnt++;
        arm();
        go();
        send_ticks(10);
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || reaction_time !== 12'd0 || valid !== 1'b0)
            $display("FAIL async_reset busy=%0b rt=%0d v=%0b expected 0 0 0", busy, reaction_time, valid);
        else pass_cnt++;
        last_reaction = 0;
        best_model = 4095;
`ifdef F1_BEST_TIME_EN
        total_cnt++;
        if (best_time !== 12'hFFF) $display("FAIL async_reset_best best=%0d expected 4095", best_time);
        else pass_cnt++;
`endif
        #2 rst = 1'b1;
        lights = 8'h00; tick = 1'b1; cyc(); cyc();
        tick = 1'b0; btn = 1'b1; cyc(); btn = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || jump_start !== 1'b0 || valid !== 1'b0)
            $display("FAIL post_reset_idle busy=%0b js=%0b v=%0b expected 0 0 0", busy, jump_start, valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind <= 1) begin
                run_round(int'($urandom_range(0, 150)), 1'($urandom_range(0, 1)), "rand_run");
            end else if (kind == 2) begin
                arm();
                lights = 8'hFF;
                for (int w = 0; w < int'($urandom_range(0, 3)); w++) cyc();
                lights = 8'($urandom); btn = 1'b1; cyc(); btn = 1'b0;
                total_cnt++;
                if (jump_start !== 1'b1 || valid !== 1'b0 || reaction_time !== 12'(last_reaction))
                    $display("FAIL rand_jump js=%0b v=%0b rt=%0d expected js=1 v=0 rt=%0d", jump_start, valid, reaction_time, last_reaction);
                else pass_cnt++;
                clr = 1'b1; lights = 8'h00; cyc(); clr = 1'b0;
            end else begin
                logic [7:0] junk;
                junk = 8'($urandom_range(1, 254));
                arm();
                lights = junk; cyc();
                total_cnt++;
                if (busy !== 1'b0 || jump_start !== 1'b0 || valid !== 1'b0 || reaction_time !== 12'(last_reaction))
                    $display("FAIL rand_abandon lights=%02h busy=%0b js=%0b v=%0b rt=%0d expected busy=0 flags=0 rt=%0d",
                             junk, busy, jump_start, valid, reaction_time, last_reaction);
                else pass_cnt++;
                lights = 8'h00; cyc();
            end
        end
    endtask

`ifdef F1_BEST_TIME_EN
    task automatic test_best_time();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        best_model = 4095;
        last_reaction = 0;
        cyc();
        run_round(50, 1'b0, "best50");
        run_round(30, 1'b0, "best30");
        run_round(40, 1'b0, "best40");
        test_timeout(1'b0);
        total_cnt++;
        if (best_time !== 12'(best_model)) $display("FAIL best_after_clr best=%0d expected %0d", best_time, best_model);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (best_time !== 12'hFFF) $display("FAIL best_reset best=%0d expected 4095", best_time);
        else pass_cnt++;
        #2 rst = 1'b1;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_jump_start();
        test_held_button();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_abandon_and_reset();
        test_random();
`ifdef F1_BEST_TIME_EN
        test_best_time();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
